// File: rtl/code_loader_pkg.sv
// Shared types and constants for the code memory loader.
// CODE_LOADER_CHECKSUM_EN adds the GET_CHK state to the state enum.
package code_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [1:0] SYNC_DEF = 2'b10;

`ifdef CODE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, GET_CNT, GET_HI, GET_LO, WRITE, GET_CHK, FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, GET_CNT, GET_HI, GET_LO, WRITE, FINISH
  } state_t;
`endif

endpackage

// File: rtl/code_mem_loader.sv
// Serial program loader: parses a SYNC/COUNT header followed by 16-bit
// payload words from a byte stream and writes them into code_mem.
// The CPU is held off while a load is in progress.
// Optional feature: define CODE_LOADER_CHECKSUM_EN for a trailing XOR
// checksum byte; a checksum mismatch raises load_err and leaves the CPU held.
module code_mem_loader
  import code_loader_pkg::*;
#(
  parameter int         ADDR_W = 6,
  parameter logic [1:0] SYNC   = SYNC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_written
);

  localparam int CNT_W = ADDR_W + 1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    target;
  logic [BYTE_W-1:0]   hi;
  logic                xfer;
  logic                last;

  // The only WRITE and FINISH cycles refuse bytes; everything else is a receive state
  assign rx_ready = (state != WRITE) && (state != FINISH);
  assign mem_we   = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign xfer     = rx_valid && rx_ready;
  assign last     = ((words_written + CNT_W'(1)) == target);

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  // Running XOR of payload bytes and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      csum     <= '0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (xfer && rx_data[7:6] == SYNC) begin
                   csum     <= '0;
                   load_err <= 1'b0;
                 end
        GET_HI,
        GET_LO:  if (xfer) csum <= csum ^ rx_data;
        GET_CHK: if (xfer && rx_data != csum) load_err <= 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign load_err = 1'b0;
`endif

  // Main loader FSM: header parse, word assembly, write strobe, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      target        <= '0;
      hi            <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Bytes without the sync pattern are consumed silently
          if (xfer && rx_data[7:6] == SYNC) begin
            addr          <= rx_data[ADDR_W-1:0];
            words_written <= '0;
            cpu_hold      <= 1'b1;
            state         <= GET_CNT;
          end
        end
        GET_CNT: begin
          if (xfer) begin
            // A zero count means the whole memory
            if (rx_data[6:0] == 7'd0) target <= CNT_W'(1) << ADDR_W;
            else                      target <= CNT_W'(rx_data[6:0]);
            state <= GET_HI;
          end
        end
        GET_HI: begin
          if (xfer) begin
            hi    <= rx_data;
            state <= GET_LO;
          end
        end
        GET_LO: begin
          if (xfer) begin
            // Address/data are captured here so they hold outside WRITE
            mem_waddr <= addr;
            mem_wdata <= {hi, rx_data};
            state     <= WRITE;
          end
        end
        WRITE: begin
          addr          <= addr + ADDR_W'(1);
          words_written <= words_written + CNT_W'(1);
          if (!last) begin
            state <= GET_HI;
          end else begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state <= GET_CHK;
`else
            state    <= FINISH;
            cpu_hold <= 1'b0;
`endif
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        GET_CHK: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state    <= FINISH;
              cpu_hold <= 1'b0;
            end else begin
              // Bad image: keep the CPU held until a good load completes
              state <= IDLE;
            end
          end
        end
`endif
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_mem_loader.sv
// Self-checking bench for code_mem_loader: table of frames, scoreboard of
// expected memory writes, plus hand-written discard/reset/checksum sequences.
module tb_code_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        load_err;
  logic [6:0]  words_written;

  int tests = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;

  typedef struct {
    logic [7:0]  sync;
    logic [7:0]  cnt;
    int          nwords;
    logic [15:0] d0;
    logic [15:0] d1;
    int          gap;
    logic [6:0]  exp_ww;
  } vec_t;

  logic [21:0] exp_q[$];

  code_mem_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .load_err(load_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {10'd0, mem_waddr, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          chk("write_addr_data", {10'd0, mem_waddr, mem_wdata}, {10'd0, e});
        end
        chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      end
      if (done) done_seen++;
    end
  end

  function automatic logic [15:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.d0;
    if (i == 1) return v.d1;
    return v.d0 ^ (16'(i) * 16'h0101);
  endfunction

  // Present one byte after gap idle cycles; returns at the negedge after the handshake
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin rx_valid = 1'b0; @(negedge clk); end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [6:0] exp_ww);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("cpu_hold_at_done", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("words_written", {25'd0, words_written}, {25'd0, exp_ww});
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0]  cs;
    logic [15:0] d;
    logic [5:0]  a;
    cs = 8'h00;
    for (int i = 0; i < v.nwords; i++) begin
      a = v.sync[5:0] + 6'(i);
      exp_q.push_back({a, word_of(v, i)});
    end
    send_byte(v.sync, 0);
    send_byte(v.cnt, 0);
    for (int i = 0; i < v.nwords; i++) begin
      d = word_of(v, i);
      send_byte(d[15:8], $urandom_range(0, v.gap));
      send_byte(d[7:0],  $urandom_range(0, v.gap));
      cs = cs ^ d[15:8] ^ d[7:0];
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`endif
    done_exp++;
    wait_done(v.exp_ww);
  endtask

  vec_t vecs[5];
  vec_t v10;

  initial begin
    vecs[0] = '{8'h80, 8'h02, 2,  16'h1234, 16'hABCD, 0, 7'd2};
    vecs[1] = '{8'hBF, 8'h02, 2,  16'h1111, 16'h2222, 0, 7'd2};
    vecs[2] = '{8'h85, 8'h03, 3,  16'hCAFE, 16'h0001, 5, 7'd3};
    vecs[3] = '{8'h80, 8'h81, 1,  16'hBEEF, 16'h0000, 2, 7'd1};
    vecs[4] = '{8'h80, 8'h00, 64, 16'h5A5A, 16'hA5A5, 0, 7'd64};
    v10     = '{8'h8A, 8'h02, 2,  16'h0F0F, 16'hF0F0, 3, 7'd2};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_waddr", {26'd0, mem_waddr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, load_err}, 32'd0);
    chk("rst_words", {25'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-sync byte in IDLE is swallowed
    send_byte(8'h45, 0);
    chk("discard_busy", {31'd0, busy}, 32'd0);
    chk("discard_hold", {31'd0, cpu_hold}, 32'd0);

    for (int k = 0; k < 5; k++) run_frame(vecs[k]);

    // cpu_hold rises the cycle after the SYNC handshake; reset mid-frame
    exp_q.push_back({6'd0, 16'h1111});
    send_byte(8'h80, 0);
    chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {25'd0, rx_ready, mem_we, cpu_hold, busy, done, load_err, 1'b0},
        {25'd0, 7'b1000000});
    chk("midrst_waddr_wdata", {10'd0, mem_waddr, mem_wdata}, 32'd0);
    chk("midrst_words", {25'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(v10);

`ifdef CODE_LOADER_CHECKSUM_EN
    // Bad checksum: error, CPU stays held, no done
    begin
      int d0;
      d0 = done_seen;
      exp_q.push_back({6'd0, 16'h1234});
      send_byte(8'h80, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h00, 0);
      repeat (3) @(negedge clk);
      chk("chk_bad_err", {31'd0, load_err}, 32'd1);
      chk("chk_bad_hold", {31'd0, cpu_hold}, 32'd1);
      chk("chk_bad_no_done", done_seen, d0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("done_count", done_seen, done_exp);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
